// File: rtl/seq_mult_ctrl.sv
// Job controller for the 6-bit sequential multiplier: loads operands, pulses its reset, waits for Run to fall, captures the product.
// Optional 2-entry operand FIFO in front of the controller when SEQ_MULT_CTRL_FIFO_EN is defined.
module seq_mult_ctrl #(
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [5:0]  in_a_i,
  input  logic [5:0]  in_b_i,
  output logic [5:0]  mult_a_o,
  output logic [5:0]  mult_b_o,
  output logic        mult_reset_o,
  input  logic        mult_run_i,
  input  logic [11:0] mult_product_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [11:0] out_product_o,
  output logic        out_err_o
);

  localparam int TC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(TIMEOUT - 1);
  localparam logic [1:0]      RC_LAST = 2'(RST_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, BUSY, DONE} state_e;

  state_e            state_q, state_d;
  logic [1:0]        rc_q, rc_d;
  logic [TC_W-1:0]   tc_q, tc_d;
  logic [5:0]        mult_a_q, mult_a_d, mult_b_q, mult_b_d;
  logic [11:0]       prod_q, prod_d;
  logic              err_q, err_d;
  logic              take;
  logic              pair_vld;
  logic [5:0]        pair_a, pair_b;

`ifdef SEQ_MULT_CTRL_FIFO_EN
  logic [11:0] fifo_q [2];
  logic [1:0]  fcnt_q;
  logic        push_req, push, pop;

  assign in_ready_o = !rst_i && (fcnt_q != 2'd2);
  assign push_req   = in_valid_i && in_ready_o;
  // An empty FIFO lets a fresh pair go straight to LOAD without queuing.
  assign pair_vld   = (fcnt_q != 2'd0) || push_req;
  assign {pair_a, pair_b} = (fcnt_q != 2'd0) ? fifo_q[0] : {in_a_i, in_b_i};
  assign push = push_req && !(take && fcnt_q == 2'd0);
  assign pop  = take && (fcnt_q != 2'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fcnt_q    <= 2'd0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          fifo_q[fcnt_q[0]] <= {in_a_i, in_b_i};
          fcnt_q            <= fcnt_q + 2'd1;
        end
        2'b01: begin
          fifo_q[0] <= fifo_q[1];
          fcnt_q    <= fcnt_q - 2'd1;
        end
        2'b11:   fifo_q[0] <= {in_a_i, in_b_i};
        default: ;
      endcase
    end
  end
`else
  assign in_ready_o = !rst_i && ((state_q == IDLE) || (state_q == DONE && out_ready_i));
  assign pair_vld   = in_valid_i && in_ready_o;
  assign pair_a     = in_a_i;
  assign pair_b     = in_b_i;
`endif

  always_comb begin
    state_d  = state_q;
    rc_d     = rc_q;
    tc_d     = tc_q;
    mult_a_d = mult_a_q;
    mult_b_d = mult_b_q;
    prod_d   = prod_q;
    err_d    = err_q;
    take     = 1'b0;
    case (state_q)
      IDLE: if (pair_vld) take = 1'b1;
      LOAD: begin
        if (rc_q == RC_LAST) begin
          state_d = BUSY;
          tc_d    = '0;
        end else begin
          rc_d = rc_q + 2'd1;
        end
      end
      BUSY: begin
        tc_d = tc_q + TC_W'(1);
        // Run may still be stale from before the load on the first BUSY edge.
        if (tc_q != '0 && !mult_run_i) begin
          state_d = DONE;
          prod_d  = mult_product_i;
          err_d   = 1'b0;
        end else if (tc_q == TC_LAST) begin
          state_d = DONE;
          prod_d  = '0;
          err_d   = 1'b1;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          if (pair_vld) take = 1'b1;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      state_d  = LOAD;
      rc_d     = '0;
      mult_a_d = pair_a;
      mult_b_d = pair_b;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rc_q     <= '0;
      tc_q     <= '0;
      mult_a_q <= '0;
      mult_b_q <= '0;
      prod_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rc_q     <= rc_d;
      tc_q     <= tc_d;
      mult_a_q <= mult_a_d;
      mult_b_q <= mult_b_d;
      prod_q   <= prod_d;
      err_q    <= err_d;
    end
  end

  assign mult_a_o      = mult_a_q;
  assign mult_b_o      = mult_b_q;
  assign mult_reset_o  = rst_i || (state_q == LOAD);
  assign out_valid_o   = (state_q == DONE);
  assign out_product_o = prod_q;
  assign out_err_o     = err_q;

endmodule
